// File: rtl/gbt_rx_pattern_checker.sv
// Receive-side GBT counter-pattern checker: locks onto {cnt,cnt} frames, counts good and bad frames,
// and requests a bitslip reset when the pattern cannot be found.
module gbt_rx_pattern_checker #(
  parameter int LOCK_FRAMES  = 8,
  parameter int UNLOCK_ERRS  = 4,
  parameter int SEEK_TIMEOUT = 1024,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 link_ready,
  input  logic                 rx_valid,
  input  logic [83:0]          data_received,
  input  logic                 clear,
  output logic                 locked,
  output logic [1:0]           state,
  output logic [31:0]          expected,
  output logic [31:0]          frame_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 bitslip_req
);

  // state | meaning
  // IDLE    | link not ready, frames ignored
  // SEEK    | waiting for a self-consistent frame to seed the counter
  // LOCKING | counting consecutive matches towards lock
  // LOCKED  | pattern locked, good/bad frames counted
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEEK    = 2'd1,
    S_LOCKING = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);
  localparam int TW = $clog2(SEEK_TIMEOUT + 1);

  state_t               st_q;
  logic [GW-1:0]        good_run;
  logic [BW-1:0]        bad_run;
  logic [TW-1:0]        seek_timer;

  logic [31:0]          value;
  logic                 self_consistent;
  logic                 match;
  logic [GW-1:0]        good_next;
  logic [BW-1:0]        bad_next;
  logic [TW-1:0]        timer_next;
  logic                 lock_done;
  logic                 timeout;
  logic [ERR_CNT_W-1:0] err_next;

  assign value           = data_received[31:0];
  assign self_consistent = (data_received[83:64] == 20'd0) && (data_received[63:32] == value);
  assign match           = self_consistent && (value == expected);
  assign good_next       = good_run + 1'b1;
  assign bad_next        = bad_run + 1'b1;
  assign timer_next      = seek_timer + 1'b1;
  assign lock_done       = match && (good_next == GW'(LOCK_FRAMES));
  assign timeout         = (timer_next == TW'(SEEK_TIMEOUT));
  assign err_next        = (&err_cnt) ? err_cnt : err_cnt + 1'b1;

  assign state = st_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= S_IDLE;
      locked      <= 1'b0;
      expected    <= '0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
      bitslip_req <= 1'b0;
      good_run    <= '0;
      bad_run     <= '0;
      seek_timer  <= '0;
    end else begin
      bitslip_req <= 1'b0;
      if (!link_ready) begin
        st_q   <= S_IDLE;
        locked <= 1'b0;
      end else begin
        case (st_q)
          S_IDLE: begin
            st_q       <= S_SEEK;
            seek_timer <= '0;
          end
          S_SEEK: begin
            if (rx_valid) begin
              if (timeout) begin
                bitslip_req <= 1'b1;
                seek_timer  <= '0;
              end else begin
                seek_timer <= timer_next;
                if (self_consistent) begin
                  expected <= value + 32'd1;
                  good_run <= GW'(1);
                  st_q     <= S_LOCKING;
                end
              end
            end
          end
          S_LOCKING: begin
            if (rx_valid) begin
              // A frame that completes lock takes precedence over a coincident timeout.
              if (lock_done) begin
                st_q       <= S_LOCKED;
                locked     <= 1'b1;
                expected   <= expected + 32'd1;
                seek_timer <= '0;
                bad_run    <= '0;
              end else if (timeout) begin
                bitslip_req <= 1'b1;
                seek_timer  <= '0;
                st_q        <= S_SEEK;
              end else begin
                seek_timer <= timer_next;
                if (match) begin
                  good_run <= good_next;
                  expected <= expected + 32'd1;
                end else if (self_consistent) begin
                  expected <= value + 32'd1;
                  good_run <= GW'(1);
                end else begin
                  st_q <= S_SEEK;
                end
              end
            end
          end
          S_LOCKED: begin
            if (rx_valid) begin
              // Advance on every frame so a single corrupt frame costs exactly one error.
              expected <= expected + 32'd1;
              if (match) begin
                frame_cnt <= frame_cnt + 32'd1;
                bad_run   <= '0;
              end else begin
                err_cnt <= err_next;
                bad_run <= bad_next;
                if (bad_next == BW'(UNLOCK_ERRS)) begin
                  st_q       <= S_SEEK;
                  locked     <= 1'b0;
                  seek_timer <= '0;
                end
              end
            end
          end
          default: begin
            st_q   <= S_IDLE;
            locked <= 1'b0;
          end
        endcase
      end
      if (clear) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
      end
    end
  end

endmodule
